store_buffer: RTL
=================

Name: store_buffer

Overview:
- Write-back store buffer between the MEM-stage store path and the single-port word data memory.
- Queues up to DEPTH pending stores in FIFO order and drains one store per cycle into the data memory write port.
- A drain happens only in cycles where no load is using the shared memory address port.
- Forwards the youngest matching buffered store to loads, so the pipeline never reads stale memory.

Parameters:
AW, 32, address width in bits (word address, same indexing as the data memory).
DW, 32, data width in bits.
DEPTH, 4, number of buffer entries; power of two, ≥2.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
st_valid  in  1  MEM stage presents a store this cycle.
st_addr  in  AW  store word address.
st_data  in  DW  store data.
st_ready  out  1  buffer can accept a store this cycle (= !full).
ld_valid  in  1  MEM stage performs a load this cycle; it owns the memory port.
ld_addr  in  AW  load word address.
ld_hit  out  1  a buffered entry matches ld_addr.
ld_fwd_data  out  DW  data of the youngest matching entry; 0 when !ld_hit.
mem_we  out  1  write enable to the data memory.
mem_addr  out  AW  address driven to the data memory (load address or drain address).
mem_wdata  out  DW  drain write data.
count  out  $clog2(DEPTH+1)  number of valid entries.
empty  out  1  count == 0.
full  out  1  count == DEPTH.

Behaviour:
- Storage: circular FIFO of {addr, data, valid}. head = oldest entry, tail = next free slot; both are log2(DEPTH)-bit pointers and wrap modulo DEPTH.
- Reset (async, while rst high): head=0, tail=0, count=0, all valid bits=0. Outputs: mem_we=0, ld_hit=0, ld_fwd_data=0, empty=1, full=0, st_ready=1.
- Entry data contents are don't-care after reset.
- Push: st_valid && st_ready at a clk edge writes {st_addr, st_data} at tail, sets that valid bit, tail++.
- st_valid while full is ignored. No entry changes; the pipeline must stall on !st_ready.
- Drain condition (combinational): drain = !empty && !ld_valid.
  - When drain: mem_we=1, mem_addr=addr[head], mem_wdata=data[head].
  - At the clk edge: clear valid[head], head++.
- Port mux: when ld_valid, mem_addr=ld_addr and mem_we=0. When neither load nor drain, mem_addr=ld_addr and mem_we=0.
- Latency:
  - A pushed store becomes drainable the cycle after the push edge.
  - The earliest memory write is one cycle after acceptance.
  - An empty buffer never writes memory in the push cycle (no bypass).
- Simultaneous push and drain in one cycle: count unchanged, head and tail both advance.
- count update: +1 on push only, -1 on drain only, unchanged otherwise.
- Forwarding (combinational):
  - Compare ld_addr with the addr of every valid entry using a full AW-bit exact match.
  - ld_hit=1 if any entry matches.
  - ld_fwd_data = data of the youngest matching entry, i.e. the nearest to tail searching backward with wrap.
  - A store being pushed in the same cycle is NOT visible to a load in that cycle. The hazard unit must not issue a load in the same cycle as a store.
  - The consumer selects ld_fwd_data over memory read data when ld_hit.
  - ld_hit and ld_fwd_data are evaluated regardless of ld_valid.
- Duplicate addresses: no coalescing. Each store drains in program order, so memory ends at the youngest value.
- Load starvation: continuous ld_valid holds the buffer. Stores back up until full, and st_ready=0 stalls the pipeline. This is accepted behaviour.
- Reset mid-operation: all pending stores are discarded and mem_we drops immediately (asynchronous).
- No combinational path from st_valid to st_ready.

Test Plan:
- Reset, then push addr 5/data 0xAAAA0001, ld_valid=0 → next cycle mem_we=1, mem_addr=5, mem_wdata=0xAAAA0001; following cycle empty=1, count=0.
- Hold ld_valid=1 (ld_addr=9), push 4 stores to addrs 1,2,3,4 → full=1, st_ready=0, mem_we=0 throughout; a fifth store (addr 7) is ignored. Release ld_valid → drains 1,2,3,4 in consecutive cycles, and addr 7 is never written.
- With ld_valid=1, push addr 8 data 0x11 then addr 8 data 0x22, then load addr 8 → ld_hit=1, ld_fwd_data=0x22. Load addr 9 → ld_hit=0, ld_fwd_data=0.
- Wrap-around: with DEPTH=4, run 10 stores interleaved with ld_valid gaps. Memory writes occur in exact program order, count tracks correctly, and forwarding of the youngest match is correct across the pointer wrap (youngest entry at index 0, older at index 3, same addr).
- Simultaneous push and drain with count=2 → count stays 2, head and tail each advance by 1.
- Assert rst asynchronously mid-cycle with 3 entries pending → mem_we=0 and count=0 immediately. After rst deasserts, no stale writes occur and ld_hit=0 for the old addresses.

Source files
------------

// File: rtl/store_buffer.sv
// Write-back store buffer: FIFO of pending stores that drains into the data
// memory whenever no load owns the memory port, with youngest-match forwarding.
module store_buffer #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_fwd_data,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Handshake: a store transfers on a rising edge where st_valid && st_ready;
    // st_ready comes from registered count only, so it never depends on st_valid.

    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic          push;
    logic          drain;
    logic [PW-1:0] fwd_idx;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        st_ready = !full;
        count    = count_q;
        push     = st_valid && !full;
        drain    = !empty && !ld_valid;
    end

    // Memory port: a load always wins; the head entry drains only in idle cycles.
    always_comb begin
        mem_we    = drain;
        mem_addr  = ld_addr;
        mem_wdata = '0;
        if (drain) begin
            mem_addr  = addr_q[head_q];
            mem_wdata = data_q[head_q];
        end
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push) begin
            addr_d[tail_q]  = st_addr;
            data_d[tail_q]  = st_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        case ({push, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Scan oldest to youngest from head; the last match seen is the youngest.
    always_comb begin
        ld_hit      = 1'b0;
        ld_fwd_data = '0;
        fwd_idx     = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr)) begin
                ld_hit      = 1'b1;
                ld_fwd_data = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule
